// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, op decode helper.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } md_state_e;

    function automatic logic is_mul_op(logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div_op(logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_div_core.sv
// Combinational 32-bit signed/unsigned divider: quotient truncates toward zero,
// remainder takes the sign of the dividend.
module md_div_core (
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        is_signed_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        div_zero_o
);

    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] safe_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    always_comb begin
        neg_a      = is_signed_i & dividend_i[31];
        neg_b      = is_signed_i & divisor_i[31];
        mag_a      = neg_a ? (~dividend_i + 32'd1) : dividend_i;
        mag_b      = neg_b ? (~divisor_i + 32'd1) : divisor_i;
        div_zero_o = (divisor_i == 32'd0);
        // Keep the divider operand nonzero so the datapath never sees x/0.
        safe_b     = div_zero_o ? 32'd1 : mag_b;
        q_mag      = mag_a / safe_b;
        r_mag      = mag_a % safe_b;
        // 0x80000000 / -1 wraps back to 0x80000000 through the negation.
        quotient_o  = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
        remainder_o = neg_a ? (~r_mag + 32'd1) : r_mag;
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers. The result is computed
// at issue and held in res_hi/res_lo; HI/LO commit together when the latency counter expires.
module mul_div_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    md_state_e        state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [31:0]      res_hi_q, res_hi_d;
    logic [31:0]      res_lo_q, res_lo_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic             mul_signed;
    logic [63:0]      prod;
    logic [31:0]      quot;
    logic [31:0]      rem;
    logic             div_zero;

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then exact.
    always_comb begin
        mul_signed = (Op == MD_MULT);
        prod = {{32{mul_signed & A[31]}}, A} * {{32{mul_signed & B[31]}}, B};
    end

    md_div_core u_div_core (
        .dividend_i  (A),
        .divisor_i   (B),
        .is_signed_i (Op == MD_DIV),
        .quotient_o  (quot),
        .remainder_o (rem),
        .div_zero_o  (div_zero)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    if (is_mul_op(Op)) begin
                        res_hi_d = prod[63:32];
                        res_lo_d = prod[31:0];
                        cnt_d    = CntW'(MULT_CYCLES);
                        state_d  = StRun;
                    end else if (is_div_op(Op)) begin
                        // Divide by zero re-commits the current HI/LO, which cannot change in RUN.
                        res_hi_d = div_zero ? hi_q : rem;
                        res_lo_d = div_zero ? lo_q : quot;
                        cnt_d    = CntW'(DIV_CYCLES);
                        state_d  = StRun;
                    end else if (Op == MD_MTHI) begin
                        hi_d = A;
                    end else if (Op == MD_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            StRun: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q <= CntW'(1)) begin
                    cnt_d   = '0;
                    hi_d    = res_hi_q;
                    lo_d    = res_lo_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign Busy = (state_q == StRun);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table through a result scoreboard, plus
// hand sequences for reset mid-run, MTHI during RUN and back-to-back issue.
module tb_mul_div_unit;
    import md_pkg::*;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb[$];
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } vec_t;

    vec_t vecs[11];

    mul_div_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .Op    (Op),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; counts Busy cycles, checks HI/LO hold, then pops and checks result.
    task automatic wait_done(input int n0, input int cyc, input string name);
        int n;
        logic [63:0] exp;
        n = n0;
        while (Busy && n < 200) begin
            chk({name, " hold"}, {HI, LO}, {cur_hi, cur_lo});
            n++;
            @(negedge Clk);
        end
        chk({name, " busy cycles"}, 64'(n), 64'(cyc));
        if (sb.size() == 0) begin
            chk({name, " scoreboard empty"}, 64'd1, 64'd0);
        end else begin
            exp = sb.pop_front();
            chk({name, " result"}, {HI, LO}, exp);
            cur_hi = exp[63:32];
            cur_lo = exp[31:0];
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input int cyc,
                          input string name);
        sb.push_back({hi, lo});
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(negedge Clk);
        Start = 1'b0;
        A     = 32'hx;
        B     = 32'hx;
        wait_done(0, cyc, name);
    endtask

    initial begin
        vecs[0]  = '{MD_MULT,  32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, "mult -1*2"};
        vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5, "multu"};
        vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div -7/2"};
        vecs[3]  = '{MD_DIVU,  32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, 10, "divu"};
        vecs[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10, "div ovf"};
        vecs[5]  = '{MD_MTHI,  32'h11, 32'd0, 32'h11, 32'h80000000, 0, "mthi"};
        vecs[6]  = '{MD_MTLO,  32'h22, 32'd0, 32'h11, 32'h22, 0, "mtlo"};
        vecs[7]  = '{MD_DIVU,  32'd5, 32'd0, 32'h11, 32'h22, 10, "divu by zero"};
        vecs[8]  = '{3'd6,     32'hDEAD, 32'd1, 32'h11, 32'h22, 0, "reserved op"};
        vecs[9]  = '{MD_MULT,  32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988, 5,
                     "mult neg"};
        vecs[10] = '{MD_DIV,   32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10, "div 7/-2"};

        Reset  = 1'b0;
        Start  = 1'b0;
        Op     = 3'd0;
        A      = '0;
        B      = '0;
        cur_hi = '0;
        cur_lo = '0;
        repeat (2) @(negedge Clk);
        chk("reset busy", 64'(Busy), 64'd0);
        chk("reset hilo", {HI, LO}, 64'd0);
        Reset = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].cyc,
                   vecs[i].name);
        end

        // Reset in the middle of a DIV discards it and clears HI/LO at once.
        Start = 1'b1;
        Op    = MD_DIV;
        A     = 32'd100;
        B     = 32'd3;
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        chk("pre-reset busy", 64'(Busy), 64'd1);
        Reset = 1'b0;
        #1;
        chk("async reset busy", 64'(Busy), 64'd0);
        chk("async reset hilo", {HI, LO}, 64'd0);
        cur_hi = '0;
        cur_lo = '0;
        sb.delete();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        run_op(MD_MULT, 32'h10000, 32'h10000, 32'd1, 32'd0, 5, "mult after reset");

        // MTLO then MULT issued on the very next cycle.
        run_op(MD_MTLO, 32'h1234, 32'd0, 32'd1, 32'h1234, 0, "mtlo b2b");
        run_op(MD_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5, "mult 3*4 b2b");

        // MTHI while Busy must be dropped.
        sb.push_back({32'hFFFFFFFF, 32'h0});
        Start = 1'b1;
        Op    = MD_MULT;
        A     = 32'h80000000;
        B     = 32'd2;
        @(negedge Clk);
        chk("busy at mthi", 64'(Busy), 64'd1);
        chk("mthi run hold", {HI, LO}, {cur_hi, cur_lo});
        Op = MD_MTHI;
        A  = 32'hDEAD;
        @(negedge Clk);
        Start = 1'b0;
        wait_done(1, 5, "mult with mthi");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
